// File: rtl/sevenseg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : sevenseg_pkg                                                     |
// | Shared 7-segment constants and helpers for the display blocks.             |
// |   SEG_0..SEG_9, SEG_BLANK : active-low segment patterns {dp,g,f,e,d,c,b,a}  |
// |   seg_decode(digit)       : BCD digit -> active-low segments, 10-15 blank   |
// |   digit_max(idx, base60)  : highest value a digit position may hold         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package sevenseg_pkg;

    // dp (bit 7) is never lit, so every pattern keeps bit 7 high.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hD8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // In base-60 mode the tens digit of each pair (odd index) stops at 5.
    function automatic logic [3:0] digit_max(input int idx, input int base60);
        return ((base60 != 0) && ((idx % 2) == 1)) ? 4'd5 : 4'd9;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seg7_scan                                                        |
// | Multiplexed 7-segment scanner for a shared-anode digit bank.               |
// |   clk    in   1        system clock                                       |
// |   reset  in   1        asynchronous active-low reset                      |
// |   count  in   4*NDIG   flat BCD digit bus, digit 0 at [3:0]                |
// |   seg_n  out  8        registered active-low segments                     |
// |   dig_n  out  NDIG     registered active-low one-hot digit enable          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module seg7_scan
    import sevenseg_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int NDIG     = 4,
    parameter int BLANK_LZ = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*NDIG-1:0]   count,
    output logic [7:0]          seg_n,
    output logic [NDIG-1:0]     dig_n
);

    localparam int c_SDIV = CLK_HZ / SCAN_HZ;
    localparam int c_SW   = (c_SDIV > 1) ? $clog2(c_SDIV) : 1;
    localparam int c_IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [c_SW-1:0] c_SCNT_LAST = c_SW'(c_SDIV - 1);
    localparam logic [c_IW-1:0] c_IDX_LAST  = c_IW'(NDIG - 1);
    localparam logic [NDIG-1:0] c_DIG0_N    = ~(NDIG'(1));

    logic [c_SW-1:0] r_scnt;
    logic [c_IW-1:0] r_idx;
    logic [7:0]      r_seg_n;
    logic [NDIG-1:0] r_dig_n;

    logic            w_step;
    logic            w_zero_run;
    logic [NDIG-1:0] w_blank;
    logic [3:0]      w_digit;
    logic            w_digit_blank;
    logic [NDIG-1:0] w_dig_n;
    logic [7:0]      w_seg_n;

    assign w_step = (r_scnt == c_SCNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scnt <= '0;
            r_idx  <= '0;
        end else if (w_step) begin
            r_scnt <= '0;
            r_idx  <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IW'(1);
        end else begin
            r_scnt <= r_scnt + c_SW'(1);
        end
    end

    // Walk from the most significant digit downward; a digit is a leading
    // zero while every digit above it (and itself) is still zero.
    always_comb begin
        w_zero_run = 1'b1;
        w_blank    = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run & (count[4*i +: 4] == 4'd0);
            w_blank[i] = (BLANK_LZ != 0) && (i > 0) && w_zero_run;
        end
    end

    always_comb begin
        w_digit       = 4'd0;
        w_digit_blank = 1'b0;
        w_dig_n       = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (r_idx == c_IW'(i)) begin
                w_digit       = count[4*i +: 4];
                w_digit_blank = w_blank[i];
                w_dig_n[i]    = 1'b0;
            end
        end
        w_seg_n = w_digit_blank ? SEG_BLANK : seg_decode(w_digit);
    end

    // Enable and pattern are registered together so a digit never shows
    // its neighbour's segments.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dig_n <= c_DIG0_N;
            r_seg_n <= SEG_0;
        end else begin
            r_dig_n <= w_dig_n;
            r_seg_n <= w_seg_n;
        end
    end

    assign seg_n = r_seg_n;
    assign dig_n = r_dig_n;

endmodule
`default_nettype wire

// File: rtl/sec_counter_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sec_counter_mux                                                  |
// | N-digit BCD up/down time counter with multiplexed 7-segment output.        |
// |   clk    in   1        system clock                                       |
// |   reset  in   1        asynchronous active-low reset                      |
// |   run    in   1        count on each tick when high                       |
// |   clear  in   1        synchronous clear of digits and prescaler          |
// |   up     in   1        count direction, 1 = up                            |
// |   count  out  4*NDIG   BCD value, digit 0 least significant               |
// |   wrap   out  1        one-cycle pulse on max->0 or 0->max                |
// |   seg_n  out  8        active-low segments {dp,g,f,e,d,c,b,a}             |
// |   dig_n  out  NDIG     active-low one-hot digit enable                    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sec_counter_mux
    import sevenseg_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int SCAN_HZ  = 1000,
    parameter int NDIG     = 4,
    parameter int BASE60   = 0,
    parameter int BLANK_LZ = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                clear,
    input  logic                up,
    output logic [4*NDIG-1:0]   count,
    output logic                wrap,
    output logic [7:0]          seg_n,
    output logic [NDIG-1:0]     dig_n
);

    localparam int c_DIV = CLK_HZ / TICK_HZ;
    localparam int c_PW  = $clog2(c_DIV);

    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(c_DIV - 1);

    logic [c_PW-1:0]   r_pre;
    logic              r_wrap;

    logic              w_tick;
    logic              w_step;
    logic [NDIG-1:0]   w_term;
    logic [NDIG-1:0]   w_cin;
    logic [4*NDIG-1:0] w_count;

    assign w_tick = (r_pre == c_PRE_LAST);
    assign w_step = w_tick & run;

    // Free-running through run=0 so that resumed counting keeps tick phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
        end else if (clear || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PW'(1);
        end
    end

    // Every digit at its terminal value (max going up, 0 going down) means
    // the whole counter rolls over on this step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= !clear && w_step && (&w_term);
        end
    end

    generate
        for (genvar i = 0; i < NDIG; i++) begin : g_dig
            localparam logic [3:0] c_MAX = digit_max(i, BASE60);

            logic [3:0] r_dig;
            logic       w_at_max;
            logic       w_at_zero;

            assign w_at_max  = (r_dig == c_MAX);
            assign w_at_zero = (r_dig == 4'd0);
            assign w_term[i] = up ? w_at_max : w_at_zero;

            // A digit steps when the step reaches it: all lower digits are
            // at their terminal value for the current direction.
            if (i == 0) begin : g_lsd
                assign w_cin[i] = w_step;
            end else begin : g_upper
                assign w_cin[i] = w_step & (&w_term[i-1:0]);
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_dig <= 4'd0;
                end else if (clear) begin
                    r_dig <= 4'd0;
                end else if (w_cin[i]) begin
                    if (up) begin
                        r_dig <= w_at_max ? 4'd0 : r_dig + 4'd1;
                    end else begin
                        r_dig <= w_at_zero ? c_MAX : r_dig - 4'd1;
                    end
                end
            end

            assign w_count[4*i +: 4] = r_dig;
        end
    endgenerate

    seg7_scan #(
        .CLK_HZ   (CLK_HZ),
        .SCAN_HZ  (SCAN_HZ),
        .NDIG     (NDIG),
        .BLANK_LZ (BLANK_LZ)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .count (w_count),
        .seg_n (seg_n),
        .dig_n (dig_n)
    );

    assign count = w_count;
    assign wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_sec_counter_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sec_counter_mux                                               |
// | Scoreboard bench: instance A is decimal with leading-zero blanking,        |
// | instance B is base-60 without blanking; both share all inputs.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sec_counter_mux;

    localparam int CLK_HZ  = 20;
    localparam int TICK_HZ = 1;
    localparam int SCAN_HZ = 10;
    localparam int NDIG    = 4;

    localparam int K_CNT_A = 0, K_WRP_A = 1, K_SEG_A = 2, K_DIG_A = 3;
    localparam int K_CNT_B = 4, K_WRP_B = 5, K_SEG_B = 6, K_DIG_B = 7;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic run   = 1'b0;
    logic clear = 1'b0;
    logic up    = 1'b1;

    logic [15:0] count_a, count_b;
    logic        wrap_a, wrap_b;
    logic [7:0]  seg_a, seg_b;
    logic [3:0]  dig_a, dig_b;

    sec_counter_mux #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SCAN_HZ(SCAN_HZ),
        .NDIG(NDIG), .BASE60(0), .BLANK_LZ(1)
    ) dut_a (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .up(up),
        .count(count_a), .wrap(wrap_a), .seg_n(seg_a), .dig_n(dig_a)
    );

    sec_counter_mux #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SCAN_HZ(SCAN_HZ),
        .NDIG(NDIG), .BASE60(1), .BLANK_LZ(0)
    ) dut_b (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .up(up),
        .count(count_b), .wrap(wrap_b), .seg_n(seg_b), .dig_n(dig_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_CNT_A: return {16'h0, count_a};
            K_WRP_A: return {31'h0, wrap_a};
            K_SEG_A: return {24'h0, seg_a};
            K_DIG_A: return {28'h0, dig_a};
            K_CNT_B: return {16'h0, count_b};
            K_WRP_B: return {31'h0, wrap_b};
            K_SEG_B: return {24'h0, seg_b};
            K_DIG_B: return {28'h0, dig_b};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: on each falling edge, compare every entry due this cycle.
    always @(negedge clk) begin
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].due <= cyc) begin
                n_checks++;
                if (sb[k].due < cyc || actual(sb[k].kind) !== sb[k].exp) begin
                    n_fail++;
                    $display("FAIL %s (cycle %0d): got %h, expected %h",
                             sb[k].name, sb[k].due, actual(sb[k].kind), sb[k].exp);
                end
                sb.delete(k);
            end
        end
    end

    task automatic push_exp(input int due, input int kind, input logic [31:0] exp,
                            input string name);
        exp_t e;
        e.due = due; e.kind = kind; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic push_cnt(input int due, input logic [15:0] a, input logic [15:0] b,
                            input string tag);
        push_exp(due, K_CNT_A, {16'h0, a}, {tag, " count A"});
        push_exp(due, K_CNT_B, {16'h0, b}, {tag, " count B"});
    endtask

    task automatic push_wrap(input int due, input logic w, input string tag);
        push_exp(due, K_WRP_A, {31'h0, w}, {tag, " wrap A"});
        push_exp(due, K_WRP_B, {31'h0, w}, {tag, " wrap B"});
    endtask

    task automatic push_reset_state(input int due, input string tag);
        push_cnt(due, 16'h0000, 16'h0000, tag);
        push_wrap(due, 1'b0, tag);
        push_exp(due, K_SEG_A, 32'hC0, {tag, " seg_n A"});
        push_exp(due, K_DIG_A, 32'hE,  {tag, " dig_n A"});
        push_exp(due, K_SEG_B, 32'hC0, {tag, " seg_n B"});
        push_exp(due, K_DIG_B, 32'hE,  {tag, " dig_n B"});
    endtask

    // Always called from the "just after rising edge" phase.
    task automatic goto_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0;
        int r2;
        int idx;
        logic [7:0] seg_exp_a [4];
        logic [7:0] seg_exp_b [4];
        logic [3:0] dig_exp   [4];

        // 0305 blanked: 5, 0, 3, blank; 05:05 unblanked: 5, 0, 5, 0
        seg_exp_a = '{8'h92, 8'hC0, 8'hB0, 8'hFF};
        seg_exp_b = '{8'h92, 8'hC0, 8'h92, 8'hC0};
        dig_exp   = '{4'hE, 4'hD, 4'hB, 4'h7};

        // Reset held for three rising edges.
        goto_cyc(3);
        push_reset_state(3, "reset");

        goto_cyc(4);
        r0    = cyc;
        reset = 1'b1;
        run   = 1'b1;
        up    = 1'b1;

        // First tick lands in cycle 20 after release, visible in cycle 21.
        push_cnt(r0 + 19, 16'h0000, 16'h0000, "first tick pre");
        push_wrap(r0 + 19, 1'b0, "first tick pre");
        push_cnt(r0 + 20, 16'h0001, 16'h0001, "first tick");
        push_wrap(r0 + 20, 1'b0, "first tick");

        // 59 and 60 ticks: decimal vs base-60 tens digit.
        push_cnt(r0 + 1180, 16'h0059, 16'h0059, "59 ticks");
        push_cnt(r0 + 1200, 16'h0060, 16'h0100, "60 ticks");
        push_wrap(r0 + 1200, 1'b0, "60 ticks");

        // Clear on a tick cycle wins over the increment; set down direction.
        goto_cyc(r0 + 1219);
        clear = 1'b1;
        up    = 1'b0;
        push_cnt(r0 + 1219, 16'h0060, 16'h0100, "before clear");
        goto_cyc(r0 + 1220);
        clear = 1'b0;
        push_cnt(r0 + 1220, 16'h0000, 16'h0000, "clear on tick");
        push_wrap(r0 + 1220, 1'b0, "clear on tick");
        push_cnt(r0 + 1239, 16'h0000, 16'h0000, "tick phase after clear");
        push_cnt(r0 + 1240, 16'h9999, 16'h5959, "down wrap");
        push_wrap(r0 + 1240, 1'b1, "down wrap");
        push_wrap(r0 + 1241, 1'b0, "down wrap end");

        // Up from all-max wraps back to zero.
        goto_cyc(r0 + 1241);
        up = 1'b1;
        push_cnt(r0 + 1259, 16'h9999, 16'h5959, "up wrap pre");
        push_cnt(r0 + 1260, 16'h0000, 16'h0000, "up wrap");
        push_wrap(r0 + 1260, 1'b1, "up wrap");
        push_wrap(r0 + 1261, 1'b0, "up wrap end");

        // run low for 35 cycles swallows two ticks, phase is kept.
        goto_cyc(r0 + 1265);
        run = 1'b0;
        push_cnt(r0 + 1299, 16'h0000, 16'h0000, "run low hold");
        push_cnt(r0 + 1300, 16'h0000, 16'h0000, "run low hold end");
        goto_cyc(r0 + 1300);
        run = 1'b1;
        push_cnt(r0 + 1319, 16'h0000, 16'h0000, "resume pre");
        push_cnt(r0 + 1320, 16'h0001, 16'h0001, "resume phase");

        // Count on to 305 ticks (05:05 in base 60), then freeze.
        push_cnt(r0 + 7399, 16'h0304, 16'h0504, "304 ticks");
        push_cnt(r0 + 7400, 16'h0305, 16'h0505, "305 ticks");
        goto_cyc(r0 + 7401);
        run = 1'b0;

        // Outputs in cycle c reflect the scan index held during cycle c-1;
        // the index steps every second cycle counted from release.
        for (int c = r0 + 7402; c <= r0 + 7409; c++) begin
            idx = ((c - 1 - r0) / 2) % 4;
            push_exp(c, K_DIG_A, {28'h0, dig_exp[idx]},   "scan dig_n A");
            push_exp(c, K_SEG_A, {24'h0, seg_exp_a[idx]}, "scan seg_n A");
            push_exp(c, K_DIG_B, {28'h0, dig_exp[idx]},   "scan dig_n B");
            push_exp(c, K_SEG_B, {24'h0, seg_exp_b[idx]}, "scan seg_n B");
        end

        // Asynchronous reset mid-scan (index 1 is showing at this point).
        goto_cyc(r0 + 7411);
        reset = 1'b0;
        push_reset_state(r0 + 7411, "async reset");

        goto_cyc(r0 + 7413);
        reset = 1'b1;
        run   = 1'b1;
        up    = 1'b1;
        r2    = cyc;
        push_cnt(r2 + 19, 16'h0000, 16'h0000, "post-reset pre");
        push_cnt(r2 + 20, 16'h0001, 16'h0001, "post-reset tick");
        push_wrap(r2 + 20, 1'b0, "post-reset tick");

        goto_cyc(r2 + 22);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
